// File: rtl/mult_sequencer.sv
// mult_sequencer: multi-cycle signed multiply controller for the EX stage.
// Runs a WIDTH-step shift-add on operand magnitudes.
// It then fixes the sign and commits the 2*WIDTH product to hi/lo.
// It stalls the pipeline while the sequence is in flight.
module mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       alu_operation,
  input  logic             ex_valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 neg;

  logic                 accept;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   product;

  // Start decode, operand magnitudes, one partial-product add, and the final sign fix.
  // Accept is masked by reset so stall is low while rst is held.
  // A squashed multiply drops stall in the same cycle, so the flushed slot is not held.
  always_comb begin
    accept  = rst && (state == IDLE) && ex_valid && (alu_operation == OP_MULT) && !flush;
    mag_a   = src_a[WIDTH-1] ? (~src_a + 1'b1) : src_a;
    mag_b   = src_b[WIDTH-1] ? (~src_b + 1'b1) : src_b;
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    product = neg ? (~acc + 1'b1) : acc;
    stall   = accept | (((state == RUN) || (state == FIX)) && !flush);
  end

  // Sequencer: latch operands, iterate WIDTH shift-add steps, fix sign, commit, pulse done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            state  <= RUN;
            busy   <= 1'b1;
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc    <= {sum, acc[WIDTH-1:1]};
            mplier <= {acc[0], mplier[WIDTH-1:1]};
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          busy <= 1'b0;
          if (flush) begin
            state <= IDLE;
          end else begin
            hi    <= product[2*WIDTH-1:WIDTH];
            lo    <= product[WIDTH-1:0];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed checks of mult_sequencer.
// Covers latency, signed products, flush, mid-run reset, pass-through ops and back-to-back multiplies.
module tb_mult_sequencer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       alu_operation;
  logic             ex_valid;
  logic             flush;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int total = 0;
  int bad   = 0;

  mult_sequencer #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_operation (alu_operation),
    .ex_valid      (ex_valid),
    .flush         (flush),
    .src_a         (src_a),
    .src_b         (src_b),
    .stall         (stall),
    .busy          (busy),
    .done          (done),
    .hi            (hi),
    .lo            (lo)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop if the sequence ever gets stuck.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic v, input logic f,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    alu_operation = op;
    ex_valid      = v;
    flush         = f;
    src_a         = a;
    src_b         = b;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Issue a multiply in the current (idle) cycle and follow it to completion.
  // The task ends in the idle cycle after DONE.
  task automatic runMult(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] expHi, input logic [WIDTH-1:0] expLo);
    int cyc;
    int stallCount;
    int doneCycle;
    applyStimulus(3'b011, 1'b1, 1'b0, a, b);
    #1;
    stallCount = stall ? 1 : 0;
    cyc        = 0;
    doneCycle  = -1;
    while (doneCycle < 0 && cyc < 50) begin
      nextCycle();
      cyc++;
      if (done) doneCycle = cyc;
      else if (stall) stallCount++;
    end
    checkOutput({tag, ".doneCycle"}, 64'(doneCycle), 64'd34);
    checkOutput({tag, ".stallCycles"}, 64'(stallCount), 64'd34);
    checkOutput({tag, ".stallInDone"}, 64'(stall), 64'd0);
    checkOutput({tag, ".busyInDone"}, 64'(busy), 64'd0);
    checkOutput({tag, ".hi"}, 64'(hi), 64'(expHi));
    checkOutput({tag, ".lo"}, 64'(lo), 64'(expLo));
    applyStimulus(3'b000, 1'b0, 1'b0, '0, '0);
    nextCycle();
    checkOutput({tag, ".donePulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(3'b000, 1'b0, 1'b0, '0, '0);
    #12;
    checkOutput("reset.stall", 64'(stall), 64'd0);
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.done", 64'(done), 64'd0);
    checkOutput("reset.hi", 64'(hi), 64'd0);
    checkOutput("reset.lo", 64'(lo), 64'd0);
    rst = 1'b1;
    nextCycle();

    runMult("m3x5", 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);
    runMult("mNeg2x3", 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runMult("mMinxMin", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    runMult("mMaxxNeg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001);

    // Flush in RUN cycle 10.
    applyStimulus(3'b011, 1'b1, 1'b0, 32'd7, 32'd9);
    for (int i = 0; i < 10; i++) nextCycle();
    flush = 1'b1;
    #1;
    checkOutput("flush.stallDrop", 64'(stall), 64'd0);
    checkOutput("flush.busyBefore", 64'(busy), 64'd1);
    nextCycle();
    checkOutput("flush.busyAfter", 64'(busy), 64'd0);
    checkOutput("flush.doneAfter", 64'(done), 64'd0);
    applyStimulus(3'b000, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("flush.stallIdle", 64'(stall), 64'd0);
    for (int i = 0; i < 36; i++) begin
      nextCycle();
      if (done) checkOutput("flush.noDone", 64'(done), 64'd0);
    end
    checkOutput("flush.hiKept", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("flush.loKept", 64'(lo), 64'h8000_0001);
    runMult("postFlush", 32'd1000, 32'hFFFF_FC18, 32'hFFFF_FFFF, 32'hFFF0_BDC0);

    // Asynchronous reset in the middle of a run.
    applyStimulus(3'b011, 1'b1, 1'b0, 32'd12, 32'd12);
    for (int i = 0; i < 5; i++) nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("midReset.busy", 64'(busy), 64'd0);
    checkOutput("midReset.stall", 64'(stall), 64'd0);
    checkOutput("midReset.done", 64'(done), 64'd0);
    checkOutput("midReset.hi", 64'(hi), 64'd0);
    checkOutput("midReset.lo", 64'(lo), 64'd0);
    applyStimulus(3'b000, 1'b0, 1'b0, '0, '0);
    nextCycle();
    rst = 1'b1;
    nextCycle();
    runMult("postReset", 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6);

    // Non-multiply operations pass straight through.
    applyStimulus(3'b010, 1'b1, 1'b0, 32'd5, 32'd6);
    #1;
    checkOutput("add.stall", 64'(stall), 64'd0);
    nextCycle();
    checkOutput("add.busy", 64'(busy), 64'd0);
    checkOutput("add.stallNext", 64'(stall), 64'd0);
    applyStimulus(3'b111, 1'b1, 1'b0, 32'd5, 32'd6);
    #1;
    checkOutput("slt.stall", 64'(stall), 64'd0);
    nextCycle();
    checkOutput("slt.busy", 64'(busy), 64'd0);
    checkOutput("slt.done", 64'(done), 64'd0);
    checkOutput("hold.hi", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("hold.lo", 64'(lo), 64'hFFFF_FFD6);
    applyStimulus(3'b000, 1'b0, 1'b0, '0, '0);
    nextCycle();

    // Back-to-back multiplies: the second starts in the cycle right after DONE.
    runMult("b2bFirst", 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
    runMult("b2bSecond", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
